// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one byte-wide synchronous RAM between an instruction-fetch (IF)
//   port and a load/store (MEM) port. One transaction runs at a time and is
//   never preempted. When both ports request in the same idle cycle, MEM wins.
//   Each transfer is split into 1..4 single-byte RAM accesses.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active low
//   if_req        fetch request, held until if_done
//   if_addr       fetch byte address
//   if_flush      branch redirect; cancels the pending fetch result
//   if_inst       fetched instruction, little-endian (registered)
//   if_done       one-cycle fetch completion pulse
//   mem_req       load/store request, held until mem_done
//   mem_we        1 = store, 0 = load
//   mem_addr      load/store byte address
//   mem_len       byte count minus one
//   mem_wdata     store data, byte 0 in bits [7:0]
//   mem_rdata     load data, zero-filled above the loaded bytes (registered)
//   mem_done      one-cycle load/store completion pulse
//   ram_din       RAM read byte, valid one cycle after its address
//   ram_dout      RAM write byte
//   ram_a         RAM byte address
//   ram_wr        RAM write enable
//   stallreq_if   if_req && !if_done
//   stallreq_mem  mem_req && !mem_done
// ---------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_inst,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    logic [1:0]  state_r;
    logic        owner_r;
    logic        we_r;
    logic [31:0] base_r;
    logic [2:0]  n_r;
    logic [2:0]  cnt_r;
    logic [31:0] wdata_r;
    logic [31:0] result_r;
    logic        flushed_r;
    logic [31:0] if_inst_r;
    logic [31:0] inst_prev_r;
    logic [31:0] mem_rdata_r;
    logic        if_done_r;
    logic        mem_done_r;

    logic        active_s;
    logic        busy_last_s;
    logic        flush_now_s;
    logic [31:0] result_next_s;
    logic [31:0] ram_a_s;
    logic [7:0]  ram_dout_s;
    logic        ram_wr_s;

    // A RAM access is issued only while bytes remain to be addressed.
    assign active_s = (state_r == ST_BUSY) && (cnt_r < n_r);

    // Reads need one extra cycle to collect the last byte; writes finish when
    // the last byte has been addressed.
    assign busy_last_s = (state_r == ST_BUSY) &&
                         (we_r ? (cnt_r == (n_r - 3'd1)) : (cnt_r == n_r));

    // Flush only matters while an IF transaction is in flight.
    assign flush_now_s = if_flush && (owner_r == OWN_IF) && (state_r != ST_IDLE);

    // A flush arriving during the pulse cycle still hides the pulse and the
    // new instruction; the previous instruction is restored on DONE exit.
    assign if_done   = if_done_r && !if_flush;
    assign if_inst   = (if_done_r && if_flush) ? inst_prev_r : if_inst_r;
    assign mem_done  = mem_done_r;
    assign mem_rdata = mem_rdata_r;

    assign stallreq_if  = if_req && !if_done;
    assign stallreq_mem = mem_req && !mem_done;

    assign ram_a    = ram_a_s;
    assign ram_dout = ram_dout_s;
    assign ram_wr   = ram_wr_s;

    // RAM bus drive: address/data/enable only during an active byte access.
    always_comb begin
        ram_a_s    = 32'd0;
        ram_dout_s = 8'd0;
        ram_wr_s   = 1'b0;
        if (active_s) begin
            ram_a_s  = base_r + {29'd0, cnt_r};
            ram_wr_s = we_r;
            if (we_r) begin
                case (cnt_r[1:0])
                    2'd0:    ram_dout_s = wdata_r[7:0];
                    2'd1:    ram_dout_s = wdata_r[15:8];
                    2'd2:    ram_dout_s = wdata_r[23:16];
                    2'd3:    ram_dout_s = wdata_r[31:24];
                    default: ram_dout_s = 8'd0;
                endcase
            end else begin
                ram_dout_s = 8'd0;
            end
        end else begin
            ram_a_s    = 32'd0;
            ram_dout_s = 8'd0;
            ram_wr_s   = 1'b0;
        end
    end

    // Read assembly: the byte addressed in cycle cnt-1 arrives in cycle cnt.
    always_comb begin
        result_next_s = result_r;
        if ((state_r == ST_BUSY) && !we_r && (cnt_r != 3'd0)) begin
            case (cnt_r)
                3'd1:    result_next_s[7:0]   = ram_din;
                3'd2:    result_next_s[15:8]  = ram_din;
                3'd3:    result_next_s[23:16] = ram_din;
                3'd4:    result_next_s[31:24] = ram_din;
                default: result_next_s        = result_r;
            endcase
        end else begin
            result_next_s = result_r;
        end
    end

    // Control FSM, transaction registers and registered results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_IF;
            we_r        <= 1'b0;
            base_r      <= 32'd0;
            n_r         <= 3'd0;
            cnt_r       <= 3'd0;
            wdata_r     <= 32'd0;
            result_r    <= 32'd0;
            flushed_r   <= 1'b0;
            if_inst_r   <= 32'd0;
            inst_prev_r <= 32'd0;
            mem_rdata_r <= 32'd0;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    flushed_r  <= 1'b0;
                    cnt_r      <= 3'd0;
                    result_r   <= 32'd0;
                    if (mem_req) begin
                        owner_r <= OWN_MEM;
                        we_r    <= mem_we;
                        base_r  <= mem_addr;
                        n_r     <= {1'b0, mem_len} + 3'd1;
                        wdata_r <= mem_wdata;
                        state_r <= ST_BUSY;
                    end else if (if_req) begin
                        owner_r <= OWN_IF;
                        we_r    <= 1'b0;
                        base_r  <= if_addr;
                        n_r     <= 3'd4;
                        wdata_r <= 32'd0;
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    result_r <= result_next_s;
                    cnt_r    <= cnt_r + 3'd1;
                    if (flush_now_s) begin
                        flushed_r <= 1'b1;
                    end else begin
                        flushed_r <= flushed_r;
                    end
                    if (busy_last_s) begin
                        state_r <= ST_DONE;
                        if (owner_r == OWN_MEM) begin
                            mem_done_r <= 1'b1;
                            if (!we_r) begin
                                mem_rdata_r <= result_next_s;
                            end else begin
                                mem_rdata_r <= mem_rdata_r;
                            end
                        end else if (!flushed_r && !if_flush) begin
                            if_done_r   <= 1'b1;
                            inst_prev_r <= if_inst_r;
                            if_inst_r   <= result_next_s;
                        end else begin
                            if_done_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    if (if_done_r && if_flush) begin
                        if_inst_r <= inst_prev_r;
                    end else begin
                        if_inst_r <= if_inst_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    if_done_r  <= 1'b0;
                    mem_done_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter: a behavioural byte RAM with one-cycle
//   read latency, a table of single transactions with hand-computed
//   latency/data, and hand-written sequences for arbitration, flush and
//   reset-abort behaviour.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_inst;
    logic        if_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        stallreq_if;
    logic        stallreq_mem;

    int n_tests;
    int n_fail;

    logic [7:0] ram [0:1023];

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_inst      (if_inst),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_len      (mem_len),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .ram_a        (ram_a),
        .ram_wr       (ram_wr),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: synchronous write, read data one cycle after the address.
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
        ram_din <= ram[ram_a[9:0]];
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input vec_t v);
        if (v.is_mem) begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_addr  = v.addr;
            mem_len   = v.len;
            mem_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
    endtask

    // Called in the request cycle T (just after an edge); returns the number
    // of cycles until the done pulse, or -1 on timeout. Leaves the bench in
    // the idle cycle following DONE.
    task automatic wait_done(input bit is_mem, input string name, output int lat);
        lat = -1;
        for (int k = 0; k < 24 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check32({name, "_stall"}, {31'd0, (is_mem ? stallreq_mem : stallreq_if)}, 32'd1);
            end
            if ((is_mem ? mem_done : if_done) === 1'b1) begin
                lat = k;
                if (is_mem) mem_req = 1'b0;
                else        if_req  = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int mem_lat;
        int if_lat;
        int rd_cnt;
        bit saw_done;
        logic [31:0] a;
        logic [31:0] wd;

        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'd0;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
        ram[10'h007] = 8'hA5;
        ram[10'h3FF] = 8'h11; ram[10'h000] = 8'h22; ram[10'h001] = 8'h33; ram[10'h002] = 8'h44;

        //            is_mem we  addr          len    wdata          exp_data       lat
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 2'd3, 32'h0,         32'h0010_0513, 6};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 2'd3, 32'hDEAD_BEEF, 32'h0,         5};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0007, 2'd0, 32'h0,         32'h0000_00A5, 3};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 2'd1, 32'h0,         32'h0000_BEEF, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0201, 2'd2, 32'h0,         32'h00DE_ADBE, 5};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0300, 2'd0, 32'h1234_5677, 32'h0,         2};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0200, 2'd3, 32'h0,         32'hDEAD_BEEF, 6};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 2'd3, 32'h0,         32'h4433_2211, 6};

        rst = 1'b0; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_len = 2'd0; mem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check32("rst_if_inst",   if_inst,   32'd0);
        check32("rst_mem_rdata", mem_rdata, 32'd0);
        check32("rst_if_done",   {31'd0, if_done},  32'd0);
        check32("rst_mem_done",  {31'd0, mem_done}, 32'd0);
        check32("rst_ram_wr",    {31'd0, ram_wr},   32'd0);
        check32("rst_ram_a",     ram_a,     32'd0);
        check32("rst_stall_if",  {31'd0, stallreq_if}, 32'd0);
        @(posedge clk);
        #1;

        // Table of single transactions.
        for (int i = 0; i < 8; i++) begin
            start_req(vecs[i]);
            wait_done(vecs[i].is_mem, $sformatf("vec%0d", i), lat);
            check32($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            if (vecs[i].is_mem && vecs[i].we) begin
                wd = vecs[i].wdata;
                for (int b = 0; b <= int'(vecs[i].len); b++) begin
                    a = vecs[i].addr + b;
                    check32($sformatf("vec%0d_ram_byte%0d", i, b), {24'd0, ram[a[9:0]]}, {24'd0, wd[8*b +: 8]});
                end
            end else if (vecs[i].is_mem) begin
                check32($sformatf("vec%0d_mem_rdata", i), mem_rdata, vecs[i].exp_data);
            end else begin
                check32($sformatf("vec%0d_if_inst", i), if_inst, vecs[i].exp_data);
            end
        end

        // IF fetch with a flush pulse at byte counter 2.
        if_req = 1'b1; if_addr = 32'h100;
        rd_cnt = 0; saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ram_wr === 1'b0 && ram_a >= 32'h100 && ram_a <= 32'h103) rd_cnt++;
            if (if_done === 1'b1) saw_done = 1'b1;
            @(posedge clk);
            #1;
            if (k == 2) begin if_flush = 1'b1; if_req = 1'b0; end
            if (k == 3) if_flush = 1'b0;
        end
        check32("flush_reads",   rd_cnt, 32'd4);
        check32("flush_no_done", {31'd0, saw_done}, 32'd0);
        check32("flush_if_inst", if_inst, 32'hDEAD_BEEF);

        // Simultaneous IF and MEM requests: MEM first, then IF.
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h7; mem_len = 2'd0;
        mem_lat = -1; if_lat = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (mem_done === 1'b1 && mem_lat < 0) begin mem_lat = k; mem_req = 1'b0; end
            if (if_done === 1'b1 && if_lat < 0) begin if_lat = k; if_req = 1'b0; end
            @(posedge clk);
            #1;
        end
        mem_req = 1'b0; if_req = 1'b0;
        check32("arb_mem_latency", mem_lat, 32'd3);
        check32("arb_if_latency",  if_lat,  32'd10);
        check32("arb_mem_rdata",   mem_rdata, 32'h0000_00A5);
        check32("arb_if_inst",     if_inst,   32'h0010_0513);

        // Reset in the middle of a store (cycle with cnt=1).
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_len = 2'd3; mem_wdata = 32'h0102_0304;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check32("abort_pre_ram_wr", {31'd0, ram_wr}, 32'd1);
        check32("abort_pre_ram_a",  ram_a, 32'h201);
        rst = 1'b0; mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check32("abort_ram_wr",    {31'd0, ram_wr}, 32'd0);
        check32("abort_ram_a",     ram_a, 32'd0);
        check32("abort_mem_rdata", mem_rdata, 32'd0);
        check32("abort_if_inst",   if_inst, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_done === 1'b1 || ram_wr === 1'b1) saw_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check32("abort_no_activity", {31'd0, saw_done}, 32'd0);
        start_req(vecs[2]);
        wait_done(1'b1, "post_abort", lat);
        check32("post_abort_latency", lat, 32'd3);
        check32("post_abort_rdata",   mem_rdata, 32'h0000_00A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
